// File: rtl/usart_tx_fifo_if.sv
// Bus-side handshake bundle between the register file, the TX FIFO and the transmitter.
interface usart_tx_fifo_if #(
  parameter int ADDR_BITS = 4
);
  logic [7:0]         write_data;
  logic               write_strobe;
  logic [7:0]         data_out;
  logic               valid;
  logic               ready;
  logic               full;
  logic               empty;
  logic [ADDR_BITS:0] count;
  logic               overflow;
  logic               clear_overflow;

  modport master (
    output write_data, write_strobe, ready, clear_overflow,
    input  data_out, valid, full, empty, count, overflow
  );

  modport slave (
    input  write_data, write_strobe, ready, clear_overflow,
    output data_out, valid, full, empty, count, overflow
  );
endinterface

// File: rtl/usart_tx_fifo.sv
// Fall-through byte FIFO feeding the USART transmitter; write visible one cycle after strobe.
// Writes while full (and not popping) are dropped and flagged in a sticky overflow bit.
module usart_tx_fifo #(
  parameter int ADDR_BITS = 4
) (
  input  logic            comm_clock,
  input  logic            reset,
  usart_tx_fifo_if.slave  bus
);
  localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] ONE   = {{ADDR_BITS{1'b0}}, 1'b1};

  logic [7:0]         r_mem [2**ADDR_BITS];
  logic [ADDR_BITS:0] r_wr_ptr;
  logic [ADDR_BITS:0] r_rd_ptr;
  logic [ADDR_BITS:0] r_count;
  logic               r_overflow;

  logic w_pop;
  logic w_push;
  logic w_drop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  always_comb begin
    w_pop  = bus.ready && bus.valid;
    w_push = bus.write_strobe && (!bus.full || w_pop);
    w_drop = bus.write_strobe && bus.full && !w_pop;
  end

  always_ff @(posedge comm_clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE;
        2'b01:   r_count <= r_count - ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop)                  r_overflow <= 1'b1;
      else if (bus.clear_overflow) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge comm_clock) begin
    if (!reset && w_push) r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= bus.write_data;
  end

  assign bus.data_out = r_mem[r_rd_ptr[ADDR_BITS-1:0]];
  assign bus.empty    = (r_count == '0);
  assign bus.full     = (r_count == DEPTH);
  assign bus.valid    = !bus.empty;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
endmodule

// File: doc/usart_tx_fifo.md
# usart_tx_fifo

Byte FIFO that sits directly upstream of the USART transmitter. It buffers bytes written by the bus interface and presents them one at a time on a valid/ready handshake. The transmitter holds `valid` until it latches the byte, then pulses `ready` for one cycle. The block runs in the `comm_clock` domain and also reports fill level and overflow status to the bus register file.

## Interface
- `ADDR_BITS`, default 4: log2 of depth; depth = 2^ADDR_BITS entries (16 by default).

- `comm_clock`  in  1  system/communication clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `write_data`  in  8  byte to enqueue.
- `write_strobe`  in  1  one-cycle request to enqueue `write_data`.
- `data_out`  out  8  byte at the FIFO head; feeds transmitter `data_in`.
- `valid`  out  1  head byte present (FIFO not empty); feeds transmitter `valid`.
- `ready`  in  1  transmitter accepted the head byte; one-cycle pulse.
- `full`  out  1  count == 2^ADDR_BITS.
- `empty`  out  1  count == 0.
- `count`  out  ADDR_BITS+1  number of stored bytes, 0..2^ADDR_BITS.
- `overflow`  out  1  sticky flag: a write was dropped.
- `clear_overflow`  in  1  one-cycle request to clear `overflow`.

## Operation
- Storage is 2^ADDR_BITS x 8 memory. Write and read pointers are ADDR_BITS+1 bits wide; the extra MSB distinguishes full from empty.
- Pointer wrap-around is natural modulo-2^(ADDR_BITS+1) arithmetic. No special case is needed at the top entry.
- push = `write_strobe` && (!`full` || pop).
- pop = `ready` && `valid`.
- `ready` is ignored while `valid` is 0; the read pointer does not move.
- On push: write `write_data` to mem[wr_ptr] and increment wr_ptr.
- On pop: increment rd_ptr.
- `count` rules:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - Arithmetic never wraps past depth or below 0.
- Full with simultaneous pop and write: the write is accepted, `count` stays at depth, and `overflow` is not set.
- Empty with simultaneous write and `ready`: there is no pop (`valid` is 0), the write is accepted, and `count` becomes 1.
- `write_strobe` while full with no pop: the byte is dropped, all pointers are unchanged, and `overflow` is set.
- `overflow` clears on `clear_overflow`. If a set and a clear occur in the same cycle, the set wins.
- `data_out` = mem[rd_ptr[ADDR_BITS-1:0]] (first-word fall-through).
  - `data_out` changes only on a pop, or when a byte is written into an empty FIFO.
  - Therefore it is stable for as long as `valid` is held, which the transmitter requires.
- `valid` = !`empty`.
- `full`, `empty`, `valid` and `count` are all derived from registered pointers/count; there is no combinational path from any input to them.

## Timing
- Reset values:
  - `valid`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0.
  - Both pointers are 0.
  - `data_out` is don't-care while `valid`=0.
  - Memory contents are not reset.
- Reset mid-operation discards all queued bytes. `valid` drops on the cycle after the `reset` edge.
- Reset has priority over `write_strobe`, `ready` and `clear_overflow` in the same cycle.
- Write-to-visible latency: a strobe at edge N makes `valid`=1 and `data_out` equal to the byte after edge N (one cycle).
- Pop latency: `ready` at edge N presents the next byte, or drops `valid` if that was the last entry, after edge N.
- `count`, `full`, `empty` and `overflow` update on the same edge as the causing push/pop/drop.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- **Fill then drain:** after reset, write 0x41..0x50 (16 strobes), then pulse `ready` 16 times.
  - Required: `count`=16 and `full`=1 after the 16th strobe.
  - Required: `data_out` sequence is 0x41..0x50 in order.
  - Required: `empty`=1 and `valid`=0 after the last pop.
- **Overflow:** when full, strobe 0x99 with `ready`=0.
  - Required: `count` stays 16, `overflow`=1, 0x99 never appears on `data_out`.
  - Then pulse `clear_overflow` together with another dropped strobe → `overflow` stays 1.
  - Then pulse `clear_overflow` alone → `overflow`=0.
- **Full with simultaneous push/pop:** full FIFO, strobe 0x77 in the same cycle as `ready`.
  - Required: `count` stays 16, no overflow.
  - Required: 0x77 emerges as the 16th byte after 15 further pops.
- **Wrap-around:** 40 interleaved write/pop pairs with values 0x00..0x27 and `count` held between 1 and 3.
  - Required: output equals input order across multiple pointer wraps.
- **Ready while empty, and reset mid-stream:**
  - `ready` pulse when empty → `count` stays 0 and no pointer moves.
  - Load 5 bytes, then assert `reset` together with `write_strobe` → `count`=0, `valid`=0, `overflow`=0.
  - The next write, 0x5A, is the first byte presented.
- **Against the transmitter:** connect to `usart_tx` with `clocks_per_bit`=4 and write 0x55, 0xA3.
  - Required: `tx_pin` shows two correct 10-bit frames.
  - Required: each byte is popped exactly once, on the transmitter's `ready` pulse.
